// File: rtl/zero_restorer_pkg.sv
// Shared definitions for the zero restorer: FSM state encoding and the
// helper that clamps a requested zero count to the data path width.
package zero_restorer_pkg;

  // Operation phases: waiting for a request, shifting, holding the result.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Shifting by more than the data width gives the same result as shifting by
  // exactly the width, so the count is limited to keep the counter narrow.
  function automatic int unsigned clamp_count(input int unsigned zero_num,
                                              input int unsigned width);
    return (zero_num > width) ? width : zero_num;
  endfunction

endpackage

// File: rtl/zero_restorer.sv
// Zero restorer: re-inserts zero_num zeros into a normalized operand by
// shifting it one bit per cycle, right (LEFT_CNT=1) or left (LEFT_CNT=0),
// and reports whether any shifted-out bit was set.
module zero_restorer
  import zero_restorer_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ZERO_WIDTH = $clog2(DATA_WIDTH + 1),
  parameter int LEFT_CNT   = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [ZERO_WIDTH-1:0] zero_num,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_sticky
);

  // The counter only ever holds 0..DATA_WIDTH after clamping.
  localparam int CNT_W = $clog2(DATA_WIDTH + 1);

  state_e                state_q;
  state_e                state_d;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  sticky_q;
  logic [CNT_W-1:0]      cnt_q;

  logic                  accept;
  logic [CNT_W-1:0]      load_cnt;
  logic [DATA_WIDTH-1:0] shifted;
  logic                  exit_bit;

  assign accept   = in_valid && (state_q == IDLE);
  assign load_cnt = CNT_W'(clamp_count(32'(zero_num), DATA_WIDTH));

  // One-bit shift step in the configured direction, plus the bit that falls off.
  always_comb begin
    if (LEFT_CNT != 0) begin
      shifted  = {1'b0, data_q[DATA_WIDTH-1:1]};
      exit_bit = data_q[0];
    end else begin
      shifted  = {data_q[DATA_WIDTH-2:0], 1'b0};
      exit_bit = data_q[DATA_WIDTH-1];
    end
  end

  // Next-state logic: load, shift until the count runs out, then hold the result.
  always_comb begin
    // NOTE: default assigned first so every path drives state_d; no latch is inferred.
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = (load_cnt == '0) ? DONE : SHIFT;
        end
      end
      SHIFT: begin
        // The counter reaches 0 on this edge when it currently reads 1.
        if (cnt_q <= CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples pre-edge values regardless of block ordering.
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath: capture on accept, shift and accumulate sticky while in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q   <= '0;
      sticky_q <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            data_q   <= in_data;
            sticky_q <= 1'b0;
            cnt_q    <= load_cnt;
          end
        end
        SHIFT: begin
          data_q   <= shifted;
          sticky_q <= sticky_q | exit_bit;
          cnt_q    <= cnt_q - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign out_data   = data_q;
  assign out_sticky = sticky_q;

endmodule

// File: tb/tb_zero_restorer.sv
// Bench for zero_restorer: a right-shifting and a left-shifting instance are
// driven with identical requests and compared against expected results.
module tb_zero_restorer;

  localparam int W  = 16;
  localparam int ZW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [ZW-1:0] zero_num;
  logic          out_ready;

  logic          in_ready_r, out_valid_r, out_sticky_r;
  logic [W-1:0]  out_data_r;
  logic          in_ready_l, out_valid_l, out_sticky_l;
  logic [W-1:0]  out_data_l;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  zero_restorer #(.DATA_WIDTH(W), .ZERO_WIDTH(ZW), .LEFT_CNT(1)) dut_r (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_r),
    .in_data(in_data), .zero_num(zero_num),
    .out_valid(out_valid_r), .out_ready(out_ready),
    .out_data(out_data_r), .out_sticky(out_sticky_r)
  );

  zero_restorer #(.DATA_WIDTH(W), .ZERO_WIDTH(ZW), .LEFT_CNT(0)) dut_l (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready_l),
    .in_data(in_data), .zero_num(zero_num),
    .out_valid(out_valid_l), .out_ready(out_ready),
    .out_data(out_data_l), .out_sticky(out_sticky_l)
  );

  typedef struct {
    logic [W-1:0]  d;
    logic [ZW-1:0] zn;
    int            hold;
    logic [W-1:0]  er;
    logic          esr;
    logic [W-1:0]  el;
    logic          esl;
    int            lat;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: the result is the operand shifted by the clamped count, and
  // sticky says whether any set bit was lost off the end.
  task automatic model(input logic [W-1:0] d, input logic [ZW-1:0] zn,
                       output logic [W-1:0] er, output logic esr,
                       output logic [W-1:0] el, output logic esl,
                       output int lat);
    int unsigned n;
    longint unsigned wide;
    n    = (int'(zn) > W) ? W : int'(zn);
    wide = longint'(d);
    er   = W'(wide >> n);
    esr  = ((wide % (64'd1 << n)) != 0);
    el   = W'((wide << n) % (64'd1 << W));
    esl  = (((wide << n) >> W) != 0);
    lat  = int'(n) + 1;
  endtask

  // Issue one request to both instances, measure latency, check results,
  // optionally stall the consumer, then release the result.
  task automatic run_op(input vec_t v, input string tag);
    int lat;
    bit got;
    logic [W-1:0] hold_r, hold_l;
    @(negedge clk);
    check({tag, ".in_ready"}, {in_ready_r, in_ready_l}, 2'b11);
    in_valid = 1'b1;
    in_data  = v.d;
    zero_num = v.zn;
    @(posedge clk);
    #1;
    lat = 1;
    got = 1'b0;
    while (!got && lat <= 40) begin
      // Requests presented while busy must be ignored.
      in_valid = 1'($urandom_range(0, 1));
      in_data  = W'($urandom);
      zero_num = ZW'($urandom);
      @(negedge clk);
      if (out_valid_r) got = 1'b1;
      else lat++;
    end
    if (!got) begin
      check({tag, ".timeout"}, 0, 1);
      in_valid = 1'b0;
      return;
    end
    check({tag, ".latency"}, lat, v.lat);
    check({tag, ".valid_l"}, out_valid_l, 1);
    check({tag, ".busy_ready"}, {in_ready_r, in_ready_l}, 2'b00);
    check({tag, ".data_r"}, out_data_r, v.er);
    check({tag, ".sticky_r"}, out_sticky_r, v.esr);
    check({tag, ".data_l"}, out_data_l, v.el);
    check({tag, ".sticky_l"}, out_sticky_l, v.esl);
    hold_r = out_data_r;
    hold_l = out_data_l;
    for (int i = 0; i < v.hold; i++) begin
      @(negedge clk);
      check({tag, ".stall_valid"}, {out_valid_r, out_valid_l}, 2'b11);
      check({tag, ".stall_ready"}, {in_ready_r, in_ready_l}, 2'b00);
      check({tag, ".stall_data"}, {out_data_r, out_data_l}, {hold_r, hold_l});
      check({tag, ".stall_sticky"}, {out_sticky_r, out_sticky_l}, {v.esr, v.esl});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".released"}, {out_valid_r, out_valid_l, in_ready_r, in_ready_l}, 4'b0011);
  endtask

  vec_t tbl[7];
  vec_t rv;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    zero_num  = '0;
    out_ready = 1'b0;

    //                d        zn  hold er       esr   el       esl   lat
    tbl[0] = '{16'h8000,  3, 0, 16'h1000, 1'b0, 16'h0000, 1'b1,  4};
    tbl[1] = '{16'h8001,  1, 1, 16'h4000, 1'b1, 16'h0002, 1'b1,  2};
    tbl[2] = '{16'hABCD,  0, 0, 16'hABCD, 1'b0, 16'hABCD, 1'b0,  1};
    tbl[3] = '{16'hFFFF, 20, 0, 16'h0000, 1'b1, 16'h0000, 1'b1, 17};
    tbl[4] = '{16'h0001,  4, 5, 16'h0000, 1'b1, 16'h0010, 1'b0,  5};
    tbl[5] = '{16'h0000, 16, 0, 16'h0000, 1'b0, 16'h0000, 1'b0, 17};
    tbl[6] = '{16'h00F0,  4, 2, 16'h000F, 1'b0, 16'h0F00, 1'b0,  5};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset.outputs",
          {in_ready_r, in_ready_l, out_valid_r, out_valid_l, out_sticky_r, out_sticky_l},
          6'b110000);
    check("reset.data", {out_data_r, out_data_l}, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(tbl[i], $sformatf("tbl%0d", i));
    end

    // Reset during SHIFT discards the operation.
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 16'hFFFF;
    zero_num = 10;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midreset.outputs",
          {in_ready_r, in_ready_l, out_valid_r, out_valid_l, out_sticky_r, out_sticky_l},
          6'b110000);
    check("midreset.data", {out_data_r, out_data_l}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    begin
      bit seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid_r || out_valid_l) seen = 1'b1;
      end
      check("midreset.no_result", seen, 0);
    end
    run_op(tbl[0], "after_reset");

    // Randomized requests against the reference model.
    for (int i = 0; i < 40; i++) begin
      rv.d    = W'($urandom);
      rv.zn   = ZW'($urandom_range(0, 2**ZW - 1));
      rv.hold = $urandom_range(0, 3);
      model(rv.d, rv.zn, rv.er, rv.esr, rv.el, rv.esl, rv.lat);
      run_op(rv, $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
